if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction fetch stage directly upstream of the decode/immediate-generation logic. It owns the PC, issues word fetches to instruction memory over a request/response interface, and buffers returned instructions with their PCs in a small in-order FIFO. It presents them to decode over a valid/ready handshake. Redirects from branch or jump resolution flush the FIFO and discard responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
DEPTH, 2, FIFO entries and maximum fetches in flight; power of 2, >= 2

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request this cycle
imem_req_ready  in  1  memory accepts the request this cycle
imem_req_addr  out  32  word-aligned fetch address (current PC)
imem_rsp_valid  in  1  response data valid; responses return in order, latency >= 1 cycle
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  control-flow redirect
redirect_pc  in  32  redirect target; bits [1:0] ignored
id_valid  out  1  FIFO head valid toward decode
id_ready  in  1  decode accepts the head
id_inst  out  32  instruction at FIFO head
id_pc  out  32  PC of the instruction at FIFO head

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC; FIFO count=0, pointers=0; inflight=0; drop=0. Outputs after reset: id_valid=0, imem_req_valid=0 during reset cycles.
- Memory resets on the same rst. Responses to pre-reset requests never arrive.
- Definitions:
  - pop = id_valid & id_ready
  - fire = imem_req_valid & imem_req_ready
  - accept_rsp = imem_rsp_valid & (drop==0)
- Request rule: imem_req_valid = ~rst & ~redirect_valid & (inflight + count - pop < DEPTH).
- Request timing: combinational from registered state plus pop. The request is sampled only on the fire cycle, so no hold or stability rule applies. imem_req_addr = pc.
- On fire: pc <= pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- inflight update: inflight <= inflight + fire - imem_rsp_valid. Dropped responses also decrement it.
- Response handling:
  - accept_rsp: push {pc_of_request, imem_rsp_data} into the FIFO. The request PC comes from a DEPTH-entry PC shadow queue written on fire.
  - imem_rsp_valid with drop>0: discard the data and drop <= drop-1.
- FIFO behaviour:
  - Registered; a pushed entry is visible on id_* the cycle after the push.
  - Simultaneous push and pop is allowed when full.
  - Overflow cannot occur by construction. A push while full is an assertion failure.
- id_valid = (count != 0). id_inst and id_pc are the head entry. They hold stable while id_valid & ~id_ready.
- Redirect cycle (redirect_valid=1), which overrides all other updates:
  - pc <= {redirect_pc[31:2],2'b00}
  - FIFO flushed (count=0). A same-cycle pop is still counted as consumed, and decode must itself squash it.
  - drop <= inflight - imem_rsp_valid, so any same-cycle response is discarded.
  - No request is issued in the redirect cycle. Fetch restarts the next cycle.
- Back-to-back redirects: the last one wins, and drop is recomputed each cycle.
- Latency:
  - Request at cycle N with response at N+L gives id_valid at N+L+1.
  - Steady state with L=1, DEPTH=2 and id_ready=1 is one instruction per cycle.
- Counter widths: inflight, count and drop are $clog2(DEPTH)+1 bits.

Decomposition:
- Shared fetch package/header holds:
  - RESET_PC default
  - NOP encoding 32'h0000_0013
  - Instruction width 32
  - FIFO entry layout {pc[31:0], inst[31:0]}
- Sub-module fetch_fifo: parameterised DEPTH x 64-bit synchronous FIFO with push, pop, flush, count, full and empty. The PC shadow queue reuses the same module at 32 bits.

Test Plan:
- Reset release, memory L=1, id_ready=1 -> imem_req_addr 0x0,0x4,0x8 on consecutive cycles; id_pc 0x0 with id_inst matching, appearing 2 cycles after the first request; one instruction per cycle afterwards.
- id_ready=0 for 5 cycles with DEPTH=2 -> exactly 2 fetches issued, imem_req_valid=0 afterwards, id_inst/id_pc stable. On id_ready=1, the next request issues in the same cycle as the pop.
- L=3 with 2 requests in flight, redirect_pc=0x100 -> both late responses discarded, id_valid=0 until the 0x100 instruction arrives, id_pc=0x100 first.
- redirect_pc=0x203 -> next imem_req_addr=0x200. Redirect in the same cycle as imem_rsp_valid -> that response is not enqueued and drop handles the remainder.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst asserted mid-stream with a full FIFO and a fetch in flight -> next cycle id_valid=0, inflight=0; first post-reset request uses RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   RESET_PC_DEFAULT : default fetch address after reset
//   NOP_INST         : canonical no-op (addi x0,x0,0), shown on id_inst when nothing is buffered
//   INST_W           : instruction word width
//   fetch_entry_t    : buffered FIFO entry {pc, inst}
package if_fetch_unit_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// fetch_fifo: small synchronous in-order FIFO.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write an entry at the tail
//   pop             : retire the head entry (ignored when empty)
//   flush           : discard every entry; overrides push and pop
//   head_data       : entry at the head (valid while !empty)
//   count           : number of stored entries, 0..DEPTH
//   full, empty     : occupancy flags
// Push and pop may happen together even when full; the write slot then equals
// the slot being retired.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & (count_reg != '0) & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign empty     = (count_reg == '0);

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && full && !pop));

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage feeding decode.
//   clk, rst                  : clock, synchronous active-high reset
//   imem_req_valid/ready/addr : word fetch request to instruction memory (addr = pc)
//   imem_rsp_valid/data       : in-order fetch responses, latency >= 1
//   redirect_valid/pc         : control-flow redirect; flushes buffered work,
//                               discards responses still in flight
//   id_valid/ready/inst/pc    : buffered instruction + PC toward decode
// Buffered entries plus outstanding fetches never exceed DEPTH, so the
// instruction FIFO cannot overflow and the PC shadow queue always holds the
// address of the next live response.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [31:0]       id_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_reg, pc_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [CW-1:0] drop_reg, drop_next;

  logic          pop, fire, accept_rsp, enqueue;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_aligned;

  fetch_entry_t  push_entry, head_entry;
  logic [CW-1:0] data_count;
  logic          data_full, data_empty;

  logic [31:0]   shadow_head;
  logic [CW-1:0] shadow_count;
  logic          shadow_full, shadow_empty;

  assign pop        = id_valid & id_ready;
  assign fire       = imem_req_valid & imem_req_ready;
  assign accept_rsp = imem_rsp_valid & (drop_reg == '0);
  // A redirect flushes both queues, so a same-cycle live response is lost too.
  assign enqueue    = accept_rsp & ~redirect_valid;

  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  // Slots already committed: every outstanding fetch (dropped ones included)
  // plus buffered entries, less the one decode takes this cycle.
  assign occupancy = {1'b0, inflight_reg} + {1'b0, data_count} - (CW+1)'(pop);

  assign imem_req_valid = ~rst & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_reg;

  always_comb begin
    pc_next       = pc_reg;
    inflight_next = inflight_reg + CW'(fire) - CW'(imem_rsp_valid);
    drop_next     = drop_reg;
    if (fire) pc_next = pc_reg + 32'd4;
    if (imem_rsp_valid && (drop_reg != '0)) drop_next = drop_reg - CW'(1);
    if (redirect_valid) begin
      // Every fetch still outstanding after this edge belongs to the old path.
      pc_next   = redirect_aligned;
      drop_next = inflight_reg - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
    end else begin
      pc_reg       <= pc_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
    end
  end

  // PCs of live outstanding fetches, oldest first. Dropped responses were
  // flushed from here at redirect time, so they do not pop it.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_pc_shadow (
    .clk       (clk),
    .rst       (rst),
    .push      (fire),
    .push_data (pc_reg),
    .pop       (enqueue),
    .flush     (redirect_valid),
    .head_data (shadow_head),
    .count     (shadow_count),
    .full      (shadow_full),
    .empty     (shadow_empty)
  );

  assign push_entry.pc   = shadow_head;
  assign push_entry.inst = imem_rsp_data;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enqueue),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_entry),
    .count     (data_count),
    .full      (data_full),
    .empty     (data_empty)
  );

  assign id_valid = ~data_empty;
  assign id_inst  = data_empty ? NOP_INST : head_entry.inst;
  assign id_pc    = head_entry.pc;

  a_shadow_has_pc: assert property (@(posedge clk) disable iff (rst)
    !(enqueue && shadow_empty));
  a_shadow_bound: assert property (@(posedge clk) disable iff (rst)
    shadow_count <= inflight_reg);
  a_no_fetch_when_full: assert property (@(posedge clk) disable iff (rst)
    !(fire && shadow_full));
  a_inst_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(enqueue && data_full && !pop));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc;

  // Second instance only exercises the address wrap from a high reset PC.
  logic        w_req_valid, w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_id_valid, w_id_ready;
  logic [31:0] w_id_inst, w_id_pc;

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc)
  );

  if_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .id_valid(w_id_valid), .id_ready(w_id_ready),
    .id_inst(w_id_inst), .id_pc(w_id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        pending[$];     // fetches issued, response not yet returned
  int          buffered;       // live responses returned, not yet consumed
  int          epoch;          // bumps on every redirect/reset
  int          last_due;
  int          lat;
  int          cyc;
  logic [31:0] exp_pc;         // next PC decode should receive
  logic [31:0] exp_req;        // next fetch address
  logic        prev_hold;
  logic [31:0] hold_pc, hold_inst;

  logic        w_fire_prev;
  logic [31:0] w_addr_prev;
  logic [31:0] w_addrs[$];
  logic        w_seen;
  logic [31:0] w_first_pc, w_first_inst;

  int n_tests, n_fail;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %08h, want %08h", name, cyc, act, exp);
    end
  endtask

  // Drive memory responses for this cycle, let outputs settle, check them
  // against the model and update the model as if the coming edge occurs.
  task automatic settle();
    req_t e;
    int   due;
    logic mpop, exp_rv, fire;
    if (rst) pending.delete();
    imem_rsp_valid = !rst && (pending.size() != 0) && (pending[0].due <= cyc);
    imem_rsp_data  = imem_rsp_valid ? memfn(pending[0].addr) : $urandom;
    w_rsp_valid    = !rst && w_fire_prev;
    w_rsp_data     = memfn(w_addr_prev);
    #1;
    if (rst) begin
      chk("rst_req_valid", imem_req_valid, 1'b0);
      buffered    = 0;
      epoch++;
      exp_pc      = RESET_PC;
      exp_req     = RESET_PC;
      last_due    = 0;
      prev_hold   = 1'b0;
      w_fire_prev = 1'b0;
    end else begin
      mpop   = (buffered != 0) && id_ready;
      exp_rv = !redirect_valid && (pending.size() + buffered - int'(mpop) < DEPTH);
      chk("req_valid", imem_req_valid, exp_rv);
      chk("id_valid", id_valid, buffered != 0);
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
      if (prev_hold) begin
        chk("hold_pc", id_pc, hold_pc);
        chk("hold_inst", id_inst, hold_inst);
      end
      if (mpop && id_valid) begin
        chk("pop_pc", id_pc, exp_pc);
        chk("pop_inst", id_inst, memfn(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      fire = imem_req_valid && imem_req_ready;
      if (imem_rsp_valid) begin
        e = pending.pop_front();
        if (e.epoch == epoch && !redirect_valid) buffered++;
      end
      if (mpop) buffered--;
      if (redirect_valid) begin
        buffered = 0;
        epoch++;
        exp_pc  = redirect_pc & ~32'h3;
        exp_req = redirect_pc & ~32'h3;
      end
      if (fire) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        pending.push_back('{addr: imem_req_addr, due: due, epoch: epoch});
        last_due = due;
        exp_req  = exp_req + 32'd4;
      end
      prev_hold = id_valid && !id_ready && !redirect_valid;
      hold_pc   = id_pc;
      hold_inst = id_inst;
      w_fire_prev = w_req_valid;
      w_addr_prev = w_req_addr;
      if (w_req_valid && w_addrs.size() < 3) w_addrs.push_back(w_req_addr);
      if (w_id_valid && !w_seen) begin
        w_seen       = 1'b1;
        w_first_pc   = w_id_pc;
        w_first_inst = w_id_inst;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_first(input string name, input logic [31:0] exp);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      settle();
      if (id_valid) begin
        chk(name, id_pc, exp);
        found = 1'b1;
      end
      advance();
    end
    chk({name, "_seen"}, found, 1'b1);
  endtask

  typedef struct {
    logic        id_ready;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_id_valid;
    logic [31:0] exp_id_pc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic ok;
    n_tests = 0; n_fail = 0; cyc = 0; epoch = 0; buffered = 0; last_due = 0;
    lat = 1; prev_hold = 1'b0; w_fire_prev = 1'b0; w_addr_prev = '0; w_seen = 1'b0;
    w_first_pc = '0; w_first_inst = '0; hold_pc = '0; hold_inst = '0;
    exp_pc = RESET_PC; exp_req = RESET_PC;
    rst = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    w_req_ready = 1'b1; w_id_ready = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0;
    w_rsp_valid = 1'b0; w_rsp_data = '0;

    // Reset release, L=1, then 5 stalled cycles and resume.
    tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    for (int i = 5; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[10] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[11] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[12] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};

    @(negedge clk);
    settle(); advance();
    settle(); advance();
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      id_ready = tbl[i].id_ready;
      settle();
      $display("[TB] vec %0d id_ready=%0b req_valid=%0b addr=%08h id_valid=%0b id_pc=%08h",
               i, id_ready, imem_req_valid, imem_req_addr, id_valid, id_pc);
      chk($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].exp_req_valid);
      if (tbl[i].exp_req_valid) chk($sformatf("tbl%0d_addr", i), imem_req_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_id_valid", i), id_valid, tbl[i].exp_id_valid);
      if (tbl[i].exp_id_valid) begin
        chk($sformatf("tbl%0d_id_pc", i), id_pc, tbl[i].exp_id_pc);
        chk($sformatf("tbl%0d_id_inst", i), id_inst, memfn(tbl[i].exp_id_pc));
      end
      advance();
    end

    // Wrap of the fetch address from a high reset PC.
    chk("wrap_count", w_addrs.size(), 3);
    if (w_addrs.size() >= 3) begin
      chk("wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", w_addrs[2], 32'h0000_0000);
    end
    chk("wrap_first_pc", w_first_pc, 32'hFFFF_FFF8);
    chk("wrap_first_inst", w_first_inst, memfn(32'hFFFF_FFF8));

    // L=3, two fetches outstanding, redirect to 0x100.
    id_ready = 1'b1; lat = 3; ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pending.size() == 2) begin ok = 1'b1; break; end
      settle(); advance();
    end
    chk("two_inflight", ok, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    settle(); advance();
    redirect_valid = 1'b0;
    wait_first("redir100_first_pc", 32'h0000_0100);

    // Misaligned redirect target.
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    settle(); advance();
    redirect_valid = 1'b0;
    settle();
    chk("align_req_valid", imem_req_valid, 1'b1);
    chk("align_req_addr", imem_req_addr, 32'h0000_0200);
    advance();

    // Redirect in the same cycle as a response.
    lat = 2; ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pending.size() != 0 && pending[0].due <= cyc) begin
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; ok = 1'b1;
      end
      settle(); advance();
      if (ok) break;
    end
    redirect_valid = 1'b0;
    chk("rsp_redirect_setup", ok, 1'b1);
    wait_first("redir300_first_pc", 32'h0000_0300);

    // Reset mid-stream with buffered data and a fetch in flight.
    lat = 3; ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (buffered > 0 && pending.size() > 0) begin ok = 1'b1; break; end
      id_ready = ($urandom_range(0, 1) == 1);
      settle(); advance();
    end
    chk("midrst_setup", ok, 1'b1);
    rst = 1'b1;
    settle(); advance();
    rst = 1'b0; id_ready = 1'b1; imem_req_ready = 1'b1;
    settle();
    chk("midrst_id_valid", id_valid, 1'b0);
    chk("midrst_req_valid", imem_req_valid, 1'b1);
    chk("midrst_req_addr", imem_req_addr, RESET_PC);
    advance();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst            = ($urandom_range(0, 199) == 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 9) < 8);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = $urandom & 32'h0000_FFFF;
      lat            = $urandom_range(1, 4);
      settle(); advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
